// File: rtl/combi_fetch.sv
// Fetch stage and IF/ID pipeline register for the combined ARM/RISC-V core.
// Keeps one imem request outstanding, parks a returned word while decode stalls, and drops stale words after a redirect.
`timescale 1ns/1ps
module combi_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic        RESET_ARM = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        armD,
  output logic        imem_req,
  output logic [31:0] PCF,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        wasNotFlushedD,
  output logic        armIn,
  output logic        fetch_bubbleF,
  output logic [1:0]  state_dbg
);

  // imem handshake: imem_req=1 presents PCF and holds it stable; memory answers
  // with a single imem_rvalid strobe at least one cycle later. Only one request
  // is ever outstanding, and imem_req drops while a word is parked or stale.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_KILL = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] fbuf;
  logic [31:0] fbuf_next;
  logic [31:0] word;
  logic        word_valid;
  logic        adv;

  assign adv       = !StallD;
  assign pc_plus4  = PCF + 32'd4;
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    pc_next    = PCF;
    fbuf_next  = fbuf;
    word       = imem_rdata;
    word_valid = 1'b0;
    imem_req   = 1'b0;
    case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_rvalid) begin
          if (PCSrcE) begin
            pc_next = PCTargetE;
          end else if (adv) begin
            word_valid = 1'b1;
            pc_next    = pc_plus4;
          end else begin
            fbuf_next  = imem_rdata;
            state_next = S_HOLD;
          end
        end else if (PCSrcE) begin
          pc_next    = PCTargetE;
          state_next = S_KILL;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          pc_next    = PCTargetE;
          state_next = S_REQ;
        end else if (adv) begin
          word       = fbuf;
          word_valid = 1'b1;
          pc_next    = pc_plus4;
          state_next = S_REQ;
        end
      end
      S_KILL: begin
        // The response for the old address is still coming; swallow it first.
        if (PCSrcE) pc_next = PCTargetE;
        if (imem_rvalid) state_next = S_REQ;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign fetch_bubbleF = adv && !word_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      PCF            <= RESET_PC;
      fbuf           <= 32'd0;
      InstrD         <= 32'd0;
      PCD            <= 32'd0;
      PCPlus4D       <= 32'd0;
      wasNotFlushedD <= 1'b0;
      armIn          <= RESET_ARM;
    end else begin
      state <= state_next;
      PCF   <= pc_next;
      fbuf  <= fbuf_next;
      if (adv) armIn <= armD;
      // A flush forces a bubble even when decode is stalled; PCD/PCPlus4D keep their value.
      if (FlushD || (adv && !word_valid)) begin
        InstrD         <= 32'd0;
        wasNotFlushedD <= 1'b0;
      end else if (adv) begin
        InstrD         <= word;
        PCD            <= PCF;
        PCPlus4D       <= pc_plus4;
        wasNotFlushedD <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_combi_fetch.sv
// Bench for combi_fetch: a latency-programmable imem model, a table of fetch vectors,
// and hand-written redirect / flush / wrap / reset sequences checked against an expected queue.
`timescale 1ns/1ps
module tb_combi_fetch;

  logic        clk;
  logic        reset;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        armD;
  logic        imem_req;
  logic [31:0] PCF;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        wasNotFlushedD;
  logic        armIn;
  logic        fetch_bubbleF;
  logic [1:0]  state_dbg;

  combi_fetch dut (
    .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .armD(armD),
    .imem_req(imem_req), .PCF(PCF), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .wasNotFlushedD(wasNotFlushedD),
    .armIn(armIn), .fetch_bubbleF(fetch_bubbleF), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int load_cnt = 0;
  int mem_lat = 1;
  logic [95:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    else if (a == 32'h4) return 32'hE2811001;
    else return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({mem_word(pc), pc, pc + 32'd4});
  endtask

  task automatic wait_loads(input int target);
    int n;
    n = 0;
    while (load_cnt < target && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    check("load_timeout", (load_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // imem model: accepts a request when idle, answers after mem_lat cycles
  logic [31:0] req_addr;
  logic        pend;
  int          cnt;
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    pend        = 1'b0;
    cnt         = 0;
    req_addr    = 32'd0;
    forever begin
      @(posedge clk); #3;
      if (imem_rvalid) begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        pend        = 1'b0;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(req_addr);
        end
      end
      if (!pend && imem_req) begin
        req_addr = PCF;
        cnt      = mem_lat;
        pend     = 1'b1;
      end
    end
  end

  // scoreboard: every real word entering D is popped against the expected queue
  initial begin
    logic [95:0] e;
    forever begin
      @(posedge clk); #1;
      if (reset || FlushD) begin
        check("bubble_wnf", {31'd0, wasNotFlushedD}, 32'd0);
        check("bubble_instr", InstrD, 32'd0);
      end else if (!StallD) begin
        if (wasNotFlushedD) begin
          load_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_word", PCD, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("d_instr", InstrD, e[95:64]);
            check("d_pc", PCD, e[63:32]);
            check("d_pcp4", PCPlus4D, e[31:0]);
          end
        end else begin
          check("adv_bubble_instr", InstrD, 32'd0);
        end
      end
    end
  end

  typedef struct {
    int          lat;
    int          stall;
    logic        armd;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t        tab[6];
  logic [31:0] prev_instr;
  int          base;

  initial begin
    tab[0] = '{1, 0, 1'b0, 32'h00, 32'h00500093};
    tab[1] = '{1, 3, 1'b0, 32'h04, 32'hE2811001};
    tab[2] = '{2, 0, 1'b1, 32'h08, 32'hC0D60008};
    tab[3] = '{3, 1, 1'b1, 32'h0C, 32'hC0D2000C};
    tab[4] = '{1, 2, 1'b0, 32'h10, 32'hC0CE0010};
    tab[5] = '{2, 0, 1'b0, 32'h14, 32'hC0CA0014};

    reset = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 32'd0; armD = 1'b0; prev_instr = 32'd0;
    mem_lat = tab[0].lat;
    repeat (2) begin @(posedge clk); #2; end
    check("rst_pcf", PCF, 32'h0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    check("rst_instr", InstrD, 32'd0);
    check("rst_pcd", PCD, 32'd0);
    check("rst_pcp4d", PCPlus4D, 32'd0);
    check("rst_wnf", {31'd0, wasNotFlushedD}, 32'd0);
    check("rst_arm", {31'd0, armIn}, 32'd0);
    reset = 1'b0;

    // linear fetch vectors with stalls and varying memory latency
    for (int i = 0; i < 6; i++) begin
      base = load_cnt;
      exp_q.push_back({tab[i].instr, tab[i].pc, tab[i].pc + 32'd4});
      armD = tab[i].armd;
      if (tab[i].stall > 0) begin
        StallD = 1'b1;
        for (int k = 0; k < tab[i].stall; k++) begin
          @(posedge clk); #2;
          if (k == 1 && tab[i].lat == 1) begin
            check("hold_state", {30'd0, state_dbg}, 32'd2);
            check("hold_req", {31'd0, imem_req}, 32'd0);
            check("hold_instr", InstrD, prev_instr);
            check("hold_no_bubble", {31'd0, fetch_bubbleF}, 32'd0);
          end
          if (k == tab[i].stall - 1) StallD = 1'b0;
        end
      end
      wait_loads(base + 1);
      check("arm_after_load", {31'd0, armIn}, {31'd0, tab[i].armd});
      check("pcf_after_load", PCF, tab[i].pc + 32'd4);
      mem_lat = (i + 1 < 6) ? tab[i + 1].lat : 3;
      prev_instr = tab[i].instr;
    end

    // redirect while 0x18 is outstanding; second redirect in KILL wins
    armD = 1'b0;
    @(posedge clk); #2;
    PCSrcE = 1'b1; PCTargetE = 32'h80; FlushD = 1'b1;
    @(posedge clk); #2;
    check("kill_state", {30'd0, state_dbg}, 32'd3);
    check("kill_req", {31'd0, imem_req}, 32'd0);
    check("kill_pcf", PCF, 32'h80);
    PCTargetE = 32'h40;
    @(posedge clk); #2;
    check("kill_pcf_latest", PCF, 32'h40);
    PCSrcE = 1'b0; FlushD = 1'b0; mem_lat = 1;
    check("kill_fetch_bubble", {31'd0, fetch_bubbleF}, 32'd1);
    base = load_cnt;
    push_exp(32'h40);
    push_exp(32'h44);
    wait_loads(base + 2);

    // flush + stall together, then mode update and flush bubble
    mem_lat = 3;
    StallD = 1'b1; FlushD = 1'b1; armD = 1'b1;
    @(posedge clk); #2;
    check("fs_wnf", {31'd0, wasNotFlushedD}, 32'd0);
    check("fs_instr", InstrD, 32'd0);
    check("fs_arm", {31'd0, armIn}, 32'd0);
    StallD = 1'b0; FlushD = 1'b0;
    @(posedge clk); #2;
    check("arm_set", {31'd0, armIn}, 32'd1);
    FlushD = 1'b1;
    @(posedge clk); #2;
    check("arm_kept", {31'd0, armIn}, 32'd1);
    check("flush_wnf", {31'd0, wasNotFlushedD}, 32'd0);
    FlushD = 1'b0;
    base = load_cnt;
    push_exp(32'h48);
    wait_loads(base + 1);

    // redirect to the last word of the address space, PC wraps to 0
    mem_lat = 2;
    @(posedge clk); #2;
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC; FlushD = 1'b1;
    @(posedge clk); #2;
    PCSrcE = 1'b0; FlushD = 1'b0;
    check("wrap_kill_state", {30'd0, state_dbg}, 32'd3);
    check("wrap_pcf", PCF, 32'hFFFF_FFFC);
    mem_lat = 1;
    base = load_cnt;
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0);
    wait_loads(base + 1);
    check("wrap_pcf_next", PCF, 32'h0);
    check("wrap_pcp4d", PCPlus4D, 32'h0);
    wait_loads(base + 2);

    // reset with a request in flight; the late response lands in IDLE
    mem_lat = 2;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    check("mid_rst_pcf", PCF, 32'h0);
    check("mid_rst_state", {30'd0, state_dbg}, 32'd0);
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_pcd", PCD, 32'd0);
    check("mid_rst_arm", {31'd0, armIn}, 32'd0);
    mem_lat = 1;
    base = load_cnt;
    push_exp(32'h0);
    wait_loads(base + 1);

    @(posedge clk); #2;
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
